data_bus_ctrl: RTL and testbench

//  Clocked, parametrised data-bus controller between the core load/store unit and NSLV memory-mapped slaves.

---
 rtl/data_bus_ctrl_pkg.sv | 38 +++
 rtl/data_bus_ctrl_if.sv | 33 +++
 rtl/data_bus_ctrl_addr_decoder.sv | 32 +++
 rtl/data_bus_ctrl.sv | 142 ++++++++++++++
 tb/tb_data_bus_ctrl.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/data_bus_ctrl_pkg.sv
// Shared encodings and default memory map for the data-bus controller.
// Imported by the decoder, the top level and the bench.
package data_bus_ctrl_pkg;

  typedef enum logic [1:0] {
    LenByte    = 2'b00,
    LenHalf    = 2'b01,
    LenWord    = 2'b10,
    LenIllegal = 2'b11
  } len_e;

  typedef enum logic [2:0] {
    CauseNone     = 3'd0,
    CauseLen      = 3'd1,
    CauseAlign    = 3'd2,
    CauseUnmapped = 3'd3,
    CauseSlvErr   = 3'd4,
    CauseTimeout  = 3'd5
  } cause_e;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StResp
  } state_e;

  localparam int unsigned DefNslv    = 3;
  localparam int unsigned DefLedW    = 8;
  localparam int unsigned DefTimeout = 16;
  localparam logic [32*DefNslv-1:0] DefSlvBase = {32'h0003_0000, 32'h0000_0000, 32'h0001_0000};
  localparam logic [32*DefNslv-1:0] DefSlvMask = {32'hFFFF_FF00, 32'hFFFF_F800, 32'hFFFF_F000};
  localparam logic [31:0] DefLedAddr = 32'h0002_0000;

  function automatic logic is_misaligned(input logic [1:0] len, input logic [1:0] addr_lo);
    return (len == LenHalf && addr_lo[0]) || (len == LenWord && addr_lo != 2'b00);
  endfunction

endpackage

// File: rtl/data_bus_ctrl_if.sv
// Core-side and slave-side bus signals of the data-bus controller.
// The controller uses the slave modport; the environment uses master.
interface data_bus_ctrl_if #(
  parameter int unsigned NSLV = 3
);
  logic              m_req;
  logic              m_rw;
  logic [1:0]        m_len;
  logic [31:0]       m_addr;
  logic [31:0]       m_wdata;
  logic [31:0]       m_rdata;
  logic              m_ack;
  logic              m_exc;
  logic [2:0]        m_exc_cause;
  logic [NSLV-1:0]   s_sel;
  logic              s_rw;
  logic [1:0]        s_len;
  logic [31:0]       s_addr;
  logic [31:0]       s_wdata;
  logic [32*NSLV-1:0] s_rdata;
  logic [NSLV-1:0]   s_ready;
  logic [NSLV-1:0]   s_err;

  modport master (
    output m_req, m_rw, m_len, m_addr, m_wdata, s_rdata, s_ready, s_err,
    input  m_rdata, m_ack, m_exc, m_exc_cause, s_sel, s_rw, s_len, s_addr, s_wdata
  );

  modport slave (
    input  m_req, m_rw, m_len, m_addr, m_wdata, s_rdata, s_ready, s_err,
    output m_rdata, m_ack, m_exc, m_exc_cause, s_sel, s_rw, s_len, s_addr, s_wdata
  );
endinterface

// File: rtl/data_bus_ctrl_addr_decoder.sv
// Combinational request decode: window hits, lowest-index one-hot select,
// LED register match and length/alignment checks.
module data_bus_ctrl_addr_decoder
  import data_bus_ctrl_pkg::*;
#(
  parameter int unsigned          NSLV     = DefNslv,
  parameter logic [32*NSLV-1:0]   SLV_BASE = DefSlvBase,
  parameter logic [32*NSLV-1:0]   SLV_MASK = DefSlvMask,
  parameter logic [31:0]          LED_ADDR = DefLedAddr
) (
  input  logic [31:0]     addr,
  input  logic [1:0]      len,
  output logic [NSLV-1:0] hit,
  output logic [NSLV-1:0] sel,
  output logic            led_hit,
  output logic            len_bad,
  output logic            misaligned
);

  always_comb begin
    hit = '0;
    for (int i = 0; i < NSLV; i++) begin
      hit[i] = (addr & SLV_MASK[32*i +: 32]) == SLV_BASE[32*i +: 32];
    end
    // Isolate the lowest set bit so overlapping windows pick the lowest index.
    sel        = hit & (~hit + NSLV'(1));
    led_hit    = (addr == LED_ADDR);
    len_bad    = (len == LenIllegal);
    misaligned = is_misaligned(len, addr[1:0]);
  end

endmodule

// File: rtl/data_bus_ctrl.sv
// Data-bus controller: decodes a core request, runs the slave sel/ready
// handshake with timeout, reports exceptions and owns the LED register.
module data_bus_ctrl
  import data_bus_ctrl_pkg::*;
#(
  parameter int unsigned        NSLV     = DefNslv,
  parameter logic [32*NSLV-1:0] SLV_BASE = DefSlvBase,
  parameter logic [32*NSLV-1:0] SLV_MASK = DefSlvMask,
  parameter logic [31:0]        LED_ADDR = DefLedAddr,
  parameter int unsigned        LED_W    = DefLedW,
  parameter int unsigned        TIMEOUT  = DefTimeout
) (
  input  logic              clk,
  input  logic              rst,
  data_bus_ctrl_if.slave    bus,
  output logic [LED_W-1:0]  led
);

  localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  state_e          state_q;
  logic [CntW-1:0] cnt_q;

  logic [NSLV-1:0] dec_hit;
  logic [NSLV-1:0] dec_sel;
  logic            dec_led_hit;
  logic            dec_len_bad;
  logic            dec_misaligned;

  logic [31:0]     sel_rdata;
  logic            sel_ready;
  logic            sel_err;

  data_bus_ctrl_addr_decoder #(
    .NSLV     (NSLV),
    .SLV_BASE (SLV_BASE),
    .SLV_MASK (SLV_MASK),
    .LED_ADDR (LED_ADDR)
  ) u_addr_decoder (
    .addr       (bus.m_addr),
    .len        (bus.m_len),
    .hit        (dec_hit),
    .sel        (dec_sel),
    .led_hit    (dec_led_hit),
    .len_bad    (dec_len_bad),
    .misaligned (dec_misaligned)
  );

  // Only the selected slave's lane and handshake are ever looked at.
  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (bus.s_sel[i]) sel_rdata |= bus.s_rdata[32*i +: 32];
    end
    sel_ready = |(bus.s_ready & bus.s_sel);
    sel_err   = |(bus.s_err & bus.s_sel);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= StIdle;
      cnt_q           <= '0;
      led             <= '0;
      bus.m_ack       <= 1'b0;
      bus.m_exc       <= 1'b0;
      bus.m_exc_cause <= CauseNone;
      bus.m_rdata     <= '0;
      bus.s_sel       <= '0;
      bus.s_rw        <= 1'b0;
      bus.s_len       <= '0;
      bus.s_addr      <= '0;
      bus.s_wdata     <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.m_req) begin
            bus.s_rw    <= bus.m_rw;
            bus.s_len   <= bus.m_len;
            bus.s_addr  <= bus.m_addr;
            bus.s_wdata <= bus.m_wdata;
            if (dec_len_bad) begin
              bus.m_ack       <= 1'b1;
              bus.m_exc       <= 1'b1;
              bus.m_exc_cause <= CauseLen;
              state_q         <= StResp;
            end else if (dec_misaligned) begin
              bus.m_ack       <= 1'b1;
              bus.m_exc       <= 1'b1;
              bus.m_exc_cause <= CauseAlign;
              state_q         <= StResp;
            end else if (dec_led_hit) begin
              bus.m_ack <= 1'b1;
              if (bus.m_rw) led <= bus.m_wdata[LED_W-1:0];
              else          bus.m_rdata <= 32'(led);
              state_q   <= StResp;
            end else if (|dec_hit) begin
              bus.s_sel <= dec_sel;
              cnt_q     <= '0;
              state_q   <= StAccess;
            end else begin
              bus.m_ack       <= 1'b1;
              bus.m_exc       <= 1'b1;
              bus.m_exc_cause <= CauseUnmapped;
              state_q         <= StResp;
            end
          end
        end
        StAccess: begin
          cnt_q <= cnt_q + CntW'(1);
          // A ready arriving in the final timeout cycle still completes normally.
          if (sel_ready) begin
            bus.s_sel <= '0;
            bus.m_ack <= 1'b1;
            if (sel_err) begin
              bus.m_exc       <= 1'b1;
              bus.m_exc_cause <= CauseSlvErr;
            end else if (!bus.s_rw) begin
              bus.m_rdata <= sel_rdata;
            end
            state_q <= StResp;
          end else if (TIMEOUT > 0 && cnt_q == CntLast) begin
            bus.s_sel       <= '0;
            bus.m_ack       <= 1'b1;
            bus.m_exc       <= 1'b1;
            bus.m_exc_cause <= CauseTimeout;
            state_q         <= StResp;
          end
        end
        StResp: begin
          bus.m_ack       <= 1'b0;
          bus.m_exc       <= 1'b0;
          bus.m_exc_cause <= CauseNone;
          bus.m_rdata     <= '0;
          state_q         <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_data_bus_ctrl.sv
// Directed and randomized bench for data_bus_ctrl with a transaction-level
// reference model of the memory map, exception priorities and latencies.
module tb_data_bus_ctrl;
  import data_bus_ctrl_pkg::*;

  localparam int unsigned NSLV    = 3;
  localparam int unsigned LED_W   = 8;
  localparam int unsigned TIMEOUT = 16;
  localparam logic [31:0] LED_A   = 32'h0002_0000;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [LED_W-1:0] led;

  int cmp_cnt  = 0;
  int fail_cnt = 0;

  // Memory map as seen by the model: index -> (base, mask).
  logic [31:0] mdl_base [NSLV] = '{32'h0001_0000, 32'h0000_0000, 32'h0003_0000};
  logic [31:0] mdl_mask [NSLV] = '{32'hFFFF_F000, 32'hFFFF_F800, 32'hFFFF_FF00};
  logic [7:0]  led_model = 8'h00;

  data_bus_ctrl_if #(.NSLV(NSLV)) bus ();

  data_bus_ctrl #(
    .NSLV     (NSLV),
    .SLV_BASE ({32'h0003_0000, 32'h0000_0000, 32'h0001_0000}),
    .SLV_MASK ({32'hFFFF_FF00, 32'hFFFF_F800, 32'hFFFF_F000}),
    .LED_ADDR (LED_A),
    .LED_W    (LED_W),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .led (led)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected outcome of one transaction; lat = selected slave's ready cycle (0 = never).
  task automatic model(input logic rw, input logic [1:0] len, input logic [31:0] addr,
                       input logic [31:0] wdata, input int lat, input logic err,
                       input logic [31:0] sdata, output logic [2:0] cause,
                       output logic [31:0] rdata, output logic [NSLV-1:0] sel,
                       output int ack_lat, output int sel_cyc);
    int idx;
    cause = 3'd0; rdata = 32'h0; sel = '0; ack_lat = 1; sel_cyc = 0; idx = -1;
    if (len == 2'b11) cause = 3'd1;
    else if ((len == 2'b01 && addr[0]) || (len == 2'b10 && addr[1:0] != 2'b00)) cause = 3'd2;
    else if (addr == LED_A) begin
      if (rw) led_model = wdata[7:0];
      else    rdata = {24'h0, led_model};
    end else begin
      for (int i = 0; i < NSLV; i++)
        if (idx < 0 && (addr & mdl_mask[i]) == mdl_base[i]) idx = i;
      if (idx < 0) cause = 3'd3;
      else begin
        sel[idx] = 1'b1;
        if (lat >= 1 && lat <= TIMEOUT) begin
          sel_cyc = lat; ack_lat = lat + 1;
          if (err) cause = 3'd4;
          else if (!rw) rdata = sdata;
        end else begin
          sel_cyc = TIMEOUT; ack_lat = TIMEOUT + 1; cause = 3'd5;
        end
      end
    end
  endtask

  // Called at posedge+1 with the DUT idle. mode: 0 drop req at ack, 1 drop right
  // after acceptance, 2 keep req through the ack cycle.
  task automatic txn(input logic rw, input logic [1:0] len, input logic [31:0] addr,
                     input logic [31:0] wdata, input int lat, input logic err,
                     input logic [31:0] sdata, input int mode);
    logic [2:0]      e_cause;
    logic [31:0]     e_rdata;
    logic [NSLV-1:0] e_sel, seen, rdy;
    int              e_lat, e_selc, n, selc;
    logic            got;
    int unsigned     noise;
    model(rw, len, addr, wdata, lat, err, sdata, e_cause, e_rdata, e_sel, e_lat, e_selc);
    bus.s_ready = '0; bus.s_err = '0;
    bus.m_req = 1'b1; bus.m_rw = rw; bus.m_len = len; bus.m_addr = addr; bus.m_wdata = wdata;
    n = 0; selc = 0; seen = '0; got = 1'b0;
    while (!got && n < 64) begin
      @(posedge clk); #1; n++;
      if (mode == 1) bus.m_req = 1'b0;
      if (bus.m_ack === 1'b1) got = 1'b1;
      else begin
        if (bus.s_sel != '0) begin selc++; seen |= bus.s_sel; end
        noise = $urandom;
        rdy = (bus.s_sel != '0 && lat != 0 && selc == lat) ? bus.s_sel : '0;
        bus.s_ready = rdy | (noise[NSLV-1:0] & ~bus.s_sel);
        bus.s_err   = (err ? rdy : '0) | (noise[NSLV+7:8] & ~bus.s_sel);
        for (int i = 0; i < NSLV; i++)
          bus.s_rdata[32*i +: 32] = bus.s_sel[i] ? sdata : $urandom;
      end
    end
    bus.s_ready = '0; bus.s_err = '0;
    if (mode != 2) bus.m_req = 1'b0;
    if (!got) begin
      cmp_cnt++; fail_cnt++;
      $display("FAIL ack_timeout: no m_ack within 64 cycles for addr %h", addr);
    end else begin
      check("ack_latency", 32'(n), 32'(e_lat));
      check("exc", 32'(bus.m_exc), 32'(e_cause != 3'd0));
      check("cause", 32'(bus.m_exc_cause), 32'(e_cause));
      check("rdata", bus.m_rdata, e_rdata);
      check("sel_seen", 32'(seen), 32'(e_sel));
      check("sel_cycles", 32'(selc), 32'(e_selc));
      check("sel_in_ack", 32'(bus.s_sel), 32'h0);
      check("s_addr", bus.s_addr, addr);
      check("s_wdata", bus.s_wdata, wdata);
      check("s_rw_len", 32'({bus.s_rw, bus.s_len}), 32'({rw, len}));
      check("led", 32'(led), 32'(led_model));
    end
    @(posedge clk); #1;
    bus.m_req = 1'b0;
    check("ack_one_cycle", 32'(bus.m_ack), 32'h0);
    check("sel_after_ack", 32'(bus.s_sel), 32'h0);
    if (mode == 2) begin
      @(posedge clk); #1;
      check("no_reaccept", 32'({bus.m_ack, bus.s_sel}), 32'h0);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_ack_exc_cause"}, 32'({bus.m_ack, bus.m_exc, bus.m_exc_cause}), 32'h0);
    check({tag, "_rdata"}, bus.m_rdata, 32'h0);
    check({tag, "_sel"}, 32'(bus.s_sel), 32'h0);
    check({tag, "_s_fields"}, bus.s_addr | bus.s_wdata | 32'({bus.s_rw, bus.s_len}), 32'h0);
    check({tag, "_led"}, 32'(led), 32'h0);
  endtask

  initial begin
    logic [31:0] addr;
    logic [1:0]  len;
    int          lat, sel_n;
    bus.m_req = 1'b0; bus.m_rw = 1'b0; bus.m_len = '0; bus.m_addr = '0; bus.m_wdata = '0;
    bus.s_rdata = '0; bus.s_ready = '0; bus.s_err = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    txn(1'b0, 2'b10, 32'h0001_0004, 32'h0, 3, 1'b0, 32'hDEAD_BEEF, 0);
    txn(1'b1, 2'b00, 32'h0002_0000, 32'h0000_00A5, 0, 1'b0, 32'h0, 0);
    txn(1'b0, 2'b10, 32'h0001_0002, 32'h0, 1, 1'b0, 32'h1111_1111, 0);
    txn(1'b0, 2'b11, 32'h0001_0000, 32'h0, 1, 1'b0, 32'h2222_2222, 0);
    txn(1'b0, 2'b10, 32'h0005_0000, 32'h0, 1, 1'b0, 32'h3333_3333, 0);
    txn(1'b0, 2'b10, 32'h0003_0010, 32'h0, 0, 1'b0, 32'h4444_4444, 0);
    txn(1'b0, 2'b10, 32'h0000_0040, 32'h0, 2, 1'b1, 32'h5555_5555, 0);
    txn(1'b0, 2'b10, 32'h0000_0100, 32'h0, 16, 1'b0, 32'h6666_6666, 2);
    txn(1'b0, 2'b00, 32'h0002_0000, 32'h0, 1, 1'b0, 32'h0, 1);
    txn(1'b1, 2'b01, 32'h0000_07FE, 32'hCAFE_F00D, 1, 1'b0, 32'h7777_7777, 1);

    for (int k = 0; k < 80; k++) begin
      case ($urandom_range(0, 5))
        0: addr = 32'h0001_0000 | ($urandom & 32'h0000_0FFF);
        1: addr = $urandom & 32'h0000_07FF;
        2: addr = 32'h0003_0000 | ($urandom & 32'h0000_00FF);
        3: addr = LED_A;
        4: addr = $urandom;
        default: addr = LED_A | 32'($urandom_range(0, 3));
      endcase
      sel_n = $urandom_range(0, 9);
      len = (sel_n == 9) ? 2'b11 : 2'(sel_n % 3);
      if ($urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
      lat = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 20) : $urandom_range(1, 5);
      txn(1'($urandom), len, addr, $urandom, lat, ($urandom_range(0, 4) == 0), $urandom,
          $urandom_range(0, 2));
    end

    // LED write, then reset during the second ACCESS cycle of a stalled read.
    txn(1'b1, 2'b10, LED_A, 32'h0000_003C, 0, 1'b0, 32'h0, 0);
    bus.m_req = 1'b1; bus.m_rw = 1'b0; bus.m_len = 2'b10; bus.m_addr = 32'h0003_0020;
    @(posedge clk); #1;
    check("mid_rst_sel_c1", 32'(bus.s_sel), 32'h4);
    @(posedge clk); #1;
    check("mid_rst_sel_c2", 32'(bus.s_sel), 32'h4);
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_sel", 32'(bus.s_sel), 32'h0);
    check("mid_rst_ack", 32'(bus.m_ack), 32'h0);
    check("mid_rst_led", 32'(led), 32'h0);
    bus.m_req = 1'b0; rst = 1'b0; led_model = 8'h00;
    @(posedge clk); #1;
    check("post_rst_idle", 32'({bus.m_ack, bus.s_sel}), 32'h0);

    txn(1'b1, 2'b00, LED_A, 32'h0000_003C, 0, 1'b0, 32'h0, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; led_model = 8'h00;
    check_reset_state("led_reset");
    @(posedge clk); #1;
    txn(1'b0, 2'b10, LED_A, 32'h0, 0, 1'b0, 32'h0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
    $finish;
  end

endmodule
